register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | register_file : multi-source register file with stalled memory writes,     |
// |                 registered read port and status flags.                     |
// | Build option  : REGFILE_BYPASS_EN forwards same-edge write data to R.      |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic        [WIDTH-1:0]         iInbox,
  input  logic        [WIDTH-1:0]         iMem,
  input  logic        [WIDTH-1:0]         iAlu,
  input  logic        [WIDTH-1:0]         iImm,
  input  logic        [1:0]               muxR,
  input  logic                            wR,
  input  logic        [$clog2(DEPTH)-1:0] wAddr,
  input  logic                            memValid,
  input  logic        [$clog2(DEPTH)-1:0] rAddr,
  output logic signed [WIDTH-1:0]         R,
  output logic                            zero,
  output logic                            neg,
  output logic                            busy,
  output logic                            err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] C_SEL_MEM = 2'b01;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_pend_addr;
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_src;
  logic             w_latch_pend;
  logic             w_err_set;
  logic [WIDTH-1:0] w_rnext;

  always_comb begin
    w_src = iAlu;
    case (muxR)
      2'b00:   w_src = iInbox;
      2'b01:   w_src = iMem;
      2'b10:   w_src = iImm;
      default: w_src = iAlu;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_we         = 1'b0;
    w_waddr      = wAddr;
    w_wdata      = w_src;
    w_latch_pend = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wR) begin
          if (muxR != C_SEL_MEM) begin
            w_we = 1'b1;
          end else if (memValid) begin
            w_we = 1'b1;
          end else begin
            w_latch_pend = 1'b1;
            w_state_nxt  = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        // A new request is dropped even when it collides with the completion.
        w_err_set = wR;
        if (memValid) begin
          w_we        = 1'b1;
          w_waddr     = r_pend_addr;
          w_wdata     = iMem;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_regs[rAddr];
`ifdef REGFILE_BYPASS_EN
    if (w_we && (w_waddr == rAddr)) begin
      w_rnext = w_wdata;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_addr <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rnext;
      if (w_latch_pend) begin
        r_pend_addr <= wAddr;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  assign R    = r_rdata;
  assign zero = (r_rdata == '0);
  assign neg  = r_rdata[WIDTH-1];
  assign busy = (r_state == S_WAIT_MEM);
  assign err  = r_err;

endmodule
`default_nettype wire
